// File: rtl/riscv_pkg.sv
// Shared RV32M multiply/divide types: func3 op encoding, FSM states and
// width-dependent operand constants.
package riscv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // Widest DW the constant helpers can produce; callers truncate to DW.
    localparam int unsigned MULDIV_MAX_DW = 128;

    // Most negative DW-bit two's complement value, 2^(dw-1).
    function automatic logic [MULDIV_MAX_DW-1:0] MULDIV_MIN(input int unsigned dw);
        return {{(MULDIV_MAX_DW-1){1'b0}}, 1'b1} << (dw - 1);
    endfunction

    // DW-bit all-ones value (-1 signed).
    function automatic logic [MULDIV_MAX_DW-1:0] MULDIV_ONES(input int unsigned dw);
        return {MULDIV_MAX_DW{1'b1}} >> (MULDIV_MAX_DW - dw);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add multiply step or
// restoring-division step over a 2*DW accumulator.
module muldiv_step #(
    parameter int unsigned DW = 32
) (
    input  logic [2*DW-1:0] acc_i,
    input  logic [DW-1:0]   operand_i,
    input  logic            is_div_i,
    output logic [2*DW-1:0] acc_o
);

    logic [DW:0] add_sum;
    logic [DW:0] sub_diff;

    always_comb begin
        // Multiply: acc = {partial, multiplier}; add on LSB then shift right.
        add_sum  = {1'b0, acc_i[2*DW-1:DW]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        // Divide: acc = {remainder, dividend/quotient}; trial-subtract the
        // shifted remainder, the borrow bit rejects the subtraction.
        sub_diff = acc_i[2*DW-1:DW-1] - {1'b0, operand_i};
        if (is_div_i) begin
            if (sub_diff[DW]) begin
                acc_o = {acc_i[2*DW-2:0], 1'b0};
            end else begin
                acc_o = {sub_diff[DW-1:0], acc_i[DW-2:0], 1'b1};
            end
        end else begin
            acc_o = {add_sum, acc_i[DW-1:1]};
        end
    end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with kill, early completion for
// divide-by-zero/overflow and an optional single-cycle multiplier.
module riscv_muldiv_unit
    import riscv_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter bit          FAST_MUL = 1'b0,
    parameter int unsigned CNTW     = $clog2(DW) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          kill_i,
    input  logic [2:0]    op_i,
    input  logic [DW-1:0] rs1_i,
    input  logic [DW-1:0] rs2_i,
    output logic          busy_o,
    output logic          valid_o,
    output logic [DW-1:0] result_o
);

    localparam logic [DW-1:0]   MIN_V    = DW'(MULDIV_MIN(DW));
    localparam logic [DW-1:0]   ONES_V   = DW'(MULDIV_ONES(DW));
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(DW - 1);

    muldiv_state_e   state_q, state_n;
    muldiv_op_e      op_q, op_in;
    logic            neg_q;
    logic [2*DW-1:0] acc_q, acc_step, fast_prod;
    logic [DW-1:0]   opnd_q;
    logic [CNTW-1:0] cnt_q;
    logic [DW-1:0]   result_q, short_res;
    logic [DW-1:0]   mag_a, mag_b;
    logic            is_div_in, signed_a, signed_b, neg_a, neg_b, res_neg_in;
    logic            div_zero, div_ovf, shortcut, accept, last_iter;

    // Sign fix-up and result selection from a final magnitude accumulator.
    function automatic logic [DW-1:0] fix_result(input muldiv_op_e op, input logic neg,
                                                 input logic [2*DW-1:0] acc);
        logic [2*DW-1:0] p;
        logic [DW-1:0]   q, r;
        p = neg ? -acc : acc;
        q = neg ? -acc[DW-1:0] : acc[DW-1:0];
        r = neg ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];
        unique case (op)
            OP_MUL:                       return p[DW-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return p[2*DW-1:DW];
            OP_DIV, OP_DIVU:              return q;
            default:                      return r;
        endcase
    endfunction

    // Operand decode: magnitudes, result sign and shortcut detection.
    always_comb begin
        op_in      = muldiv_op_e'(op_i);
        is_div_in  = op_i[2];
        signed_a   = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        signed_b   = op_in inside {OP_MULH, OP_DIV, OP_REM};
        neg_a      = signed_a & rs1_i[DW-1];
        neg_b      = signed_b & rs2_i[DW-1];
        mag_a      = neg_a ? -rs1_i : rs1_i;
        mag_b      = neg_b ? -rs2_i : rs2_i;
        res_neg_in = (op_in == OP_REM) ? neg_a : (neg_a ^ neg_b);
        div_zero   = is_div_in && (rs2_i == '0);
        div_ovf    = (op_in == OP_DIV || op_in == OP_REM) && (rs1_i == MIN_V) && (rs2_i == ONES_V);
        shortcut   = div_zero || div_ovf || (FAST_MUL && !is_div_in);
        accept     = (state_q == IDLE || state_q == DONE) && start_i && !kill_i;
        last_iter  = (cnt_q == LAST_CNT);
    end

    if (FAST_MUL) begin : g_fast_mul
        assign fast_prod = {{DW{1'b0}}, mag_a} * {{DW{1'b0}}, mag_b};
    end else begin : g_iter_mul
        assign fast_prod = '0;
    end

    always_comb begin
        short_res = '0;
        if (div_zero) begin
            short_res = op_i[1] ? rs1_i : ONES_V;
        end else if (div_ovf) begin
            short_res = op_i[1] ? '0 : MIN_V;
        end else begin
            short_res = fix_result(op_in, res_neg_in, fast_prod);
        end
    end

    muldiv_step #(.DW(DW)) u_step (
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .is_div_i  (op_q[2]),
        .acc_o     (acc_step)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        if (kill_i) begin
            state_n = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: state_n = start_i ? (shortcut ? DONE : CALC) : IDLE;
                CALC:       state_n = last_iter ? DONE : CALC;
                default:    state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o  = (state_q == CALC);
        valid_o = (state_q == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q  <= op_in;
            neg_q <= res_neg_in;
            cnt_q <= '0;
            if (is_div_in) begin
                acc_q  <= {{DW{1'b0}}, mag_a};
                opnd_q <= mag_b;
            end else begin
                acc_q  <= {{DW{1'b0}}, mag_b};
                opnd_q <= mag_a;
            end
            if (shortcut) begin
                result_q <= short_res;
            end
        end else if (state_q == CALC && !kill_i) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
            // The result register is loaded from the final step output so it
            // changes only on the transition into DONE.
            if (last_iter) begin
                result_q <= fix_result(op_q, neg_q, acc_step);
            end
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit: iterative and single-cycle-multiply
// instances driven with directed RV32M vectors.
module tb_riscv_muldiv_unit;
    import riscv_pkg::*;

    localparam int unsigned DW = 32;

    typedef struct {
        string       name;
        logic [31:0] res;
        int unsigned issue;
        int unsigned lat;
        int unsigned busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start, kill, f_start;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        busy, valid, f_busy, f_valid;
    logic [31:0] result, f_result;

    exp_t        q[$];
    exp_t        fq[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned bcnt = 0;
    int unsigned fbcnt = 0;
    int unsigned last_issue = 0;
    logic [31:0] last_res = 32'h0;

    riscv_muldiv_unit #(.DW(DW), .FAST_MUL(1'b0)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .kill_i(kill), .op_i(op),
        .rs1_i(rs1), .rs2_i(rs2), .busy_o(busy), .valid_o(valid), .result_o(result)
    );

    riscv_muldiv_unit #(.DW(DW), .FAST_MUL(1'b1)) u_fast (
        .clk_i(clk), .rst_i(rst_n), .start_i(f_start), .kill_i(1'b0), .op_i(op),
        .rs1_i(rs1), .rs2_i(rs2), .busy_o(f_busy), .valid_o(f_valid), .result_o(f_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic score(input exp_t e, input logic b, input logic [31:0] r, input int unsigned bc);
        chk({e.name, "_result"}, r, e.res);
        chk({e.name, "_latency"}, cyc - e.issue, e.lat);
        chk({e.name, "_busy_cycles"}, bc, e.busy);
        chk({e.name, "_busy_at_valid"}, {31'b0, b}, 32'h0);
    endtask

    // Monitors: pop one expectation per valid pulse.
    always @(negedge clk) if (rst_n) begin
        if (valid) begin
            if (q.size() == 0) chk("unexpected_valid", 32'h1, 32'h0);
            else score(q.pop_front(), busy, result, bcnt);
            bcnt = 0;
        end else if (busy) bcnt++;
        else bcnt = 0;
    end

    always @(negedge clk) if (rst_n) begin
        if (f_valid) begin
            if (fq.size() == 0) chk("fast_unexpected_valid", 32'h1, 32'h0);
            else score(fq.pop_front(), f_busy, f_result, fbcnt);
            fbcnt = 0;
        end else if (f_busy) fbcnt++;
        else fbcnt = 0;
    end

    task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit sc, input bit fast);
        exp_t e;
        op = o; rs1 = a; rs2 = b;
        e.name = nm; e.res = exp; e.issue = cyc;
        e.lat  = sc ? 1 : 33;
        e.busy = sc ? 0 : 32;
        last_issue = cyc;
        if (fast) begin
            f_start = 1'b1; fq.push_back(e);
        end else begin
            start = 1'b1; q.push_back(e); last_res = exp;
        end
        @(negedge clk);
        start = 1'b0; f_start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0 && fq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_pending", 32'(q.size() + fq.size()), 32'h0);
        q.delete(); fq.delete();
        @(negedge clk);
    endtask

    task automatic run(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit sc, input bit fast);
        issue(nm, o, a, b, exp, sc, fast);
        drain();
    endtask

    initial begin
        start = 1'b0; kill = 1'b0; f_start = 1'b0;
        op = 3'b000; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_valid", {31'b0, valid}, 32'h0);
        chk("reset_result", result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run("mul",          OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0);
        run("mulh",         OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0);
        run("mulhu",        OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
        run("mulhsu",       OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0);
        run("div_neg",      OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0);
        run("rem_neg",      OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0);
        run("div_negdiv",   OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0);
        run("rem_negdiv",   OP_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        run("divu",         OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b0, 1'b0);
        run("remu",         OP_REMU,   32'd100,      32'd7,        32'd2,        1'b0, 1'b0);
        run("divu_zero",    OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
        run("div_zero",     OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
        run("rem_zero",     OP_REM,    32'd5,        32'd0,        32'd5,        1'b1, 1'b0);
        run("remu_zero",    OP_REMU,   32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1'b1, 1'b0);
        run("div_ovf",      OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0);
        run("rem_ovf",      OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        run("mul_shift",    OP_MUL,    32'h12345678, 32'h10,       32'h23456780, 1'b0, 1'b0);

        // Kill in cycle 10 of a divide: no valid, result keeps its old value.
        op = OP_DIV; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1; last_issue = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc - last_issue < 10) @(negedge clk);
        chk("busy_in_calc", {31'b0, busy}, 32'h1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", {31'b0, busy}, 32'h0);
        chk("kill_valid", {31'b0, valid}, 32'h0);
        chk("kill_result", result, last_res);
        repeat (40) @(negedge clk);

        // Kill together with start: nothing is accepted.
        op = OP_DIVU; rs1 = 32'd5; rs2 = 32'd0; start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        chk("killstart_busy", {31'b0, busy}, 32'h0);
        chk("killstart_valid", {31'b0, valid}, 32'h0);
        repeat (5) @(negedge clk);
        chk("killstart_result", result, last_res);

        // Back-to-back: second start lands in the DONE cycle of the first.
        issue("b2b_divu", OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0);
        while (cyc - last_issue < 33) @(negedge clk);
        issue("b2b_remu", OP_REMU, 32'd9, 32'd4, 32'd1, 1'b0, 1'b0);
        drain();

        // Asynchronous reset in the middle of CALC.
        op = OP_MUL; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        run("fast_mul",    OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1, 1'b1);
        run("fast_mulh",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b1, 1'b1);
        run("fast_mulhu",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b1);
        run("fast_mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b1, 1'b1);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
